// File: rtl/ingress_arb_pkg.sv
// rtl/ingress_arb_pkg.sv - shared types and constants for the ingress fabric arbiter
//
// Purpose : scheduler state encoding, default sizing and the watchdog
//           width helper used by the arbiter top level and its picker.
// Ports   : none (package).

package ingress_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

  localparam int NUM_PORTS_DFLT  = 15;
  localparam int TIMEOUT_DFLT    = 64;
  localparam int GAP_CYCLES_DFLT = 1;
  localparam int COUNT_W         = 16;

  // Watchdog needs to hold TIMEOUT-1 plus headroom for the compare.
  function automatic int wdog_width(input int timeout);
    return $clog2(timeout) + 1;
  endfunction

endpackage

// File: rtl/ingress_fabric_arbiter_if.sv
// rtl/ingress_fabric_arbiter_if.sv - ingress request / shared frame bus bundle
//
// Purpose : groups per-port request status, the shared frame beat strobes
//           and the grant/abort outputs of the arbiter.
// Ports   : none; modport slave is the arbiter, modport master is the
//           PacketBuffering / frame-bus side.
//   port_link_up  per-port link status (master -> slave)
//   frame_ready   per-port committed-frame flag (master -> slave)
//   frame_valid   shared bus beat valid (master -> slave)
//   frame_last    shared bus final beat (master -> slave)
//   forward_en    one-hot grant (slave -> master)
//   grant_port    binary index of granted port (slave -> master)
//   timeout_evt   abort pulse (slave -> master)
//   timeout_count saturating abort count (slave -> master)

interface ingress_fabric_arbiter_if
  import ingress_arb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DFLT,
  parameter int IDX_W     = $clog2(NUM_PORTS)
);

  logic [NUM_PORTS-1:0] port_link_up;
  logic [NUM_PORTS-1:0] frame_ready;
  logic                 frame_valid;
  logic                 frame_last;
  logic [NUM_PORTS-1:0] forward_en;
  logic [IDX_W-1:0]     grant_port;
  logic                 timeout_evt;
  logic [COUNT_W-1:0]   timeout_count;

  modport slave (
    input  port_link_up, frame_ready, frame_valid, frame_last,
    output forward_en, grant_port, timeout_evt, timeout_count
  );

  modport master (
    output port_link_up, frame_ready, frame_valid, frame_last,
    input  forward_en, grant_port, timeout_evt, timeout_count
  );

endinterface

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin winner select
//
// Purpose : returns the first set request at or after ptr, wrapping modulo
//           NUM_PORTS, using a double-width masked priority encoder.
// Ports   :
//   req    in  NUM_PORTS  eligible requesters
//   ptr    in  IDX_W      search start index
//   found  out 1          any request set
//   winner out IDX_W      index of the winning requester

module rr_priority_pick
  import ingress_arb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DFLT,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 found,
  output logic [IDX_W-1:0]     winner
);

  logic [2*NUM_PORTS-1:0] dbl;

  // Lower copy is masked below ptr, upper copy is the unmasked wrap-around;
  // the lowest set bit of the concatenation is the round-robin winner.
  always_comb begin
    dbl    = {req, req};
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (i < int'(ptr)) dbl[i] = 1'b0;
    end
    // Scan downward so the last hit written is the lowest index.
    for (int j = 2*NUM_PORTS-1; j >= 0; j--) begin
      if (dbl[j]) begin
        found  = 1'b1;
        winner = (j >= NUM_PORTS) ? IDX_W'(j - NUM_PORTS) : IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/ingress_fabric_arbiter.sv
// rtl/ingress_fabric_arbiter.sv - round-robin whole-frame scheduler for ingress FIFOs
//
// Purpose : grants one ingress port at a time for one whole frame onto the
//           shared frame path, with a watchdog on grants that never start.
// Ports   :
//   clk_ram_ctl  in  sole clock, rising edge
//   rst_n        in  asynchronous active-low reset
//   bus          slave modport of ingress_fabric_arbiter_if (requests,
//                frame strobes, grant and abort outputs)

module ingress_fabric_arbiter
  import ingress_arb_pkg::*;
#(
  parameter int NUM_PORTS  = NUM_PORTS_DFLT,
  parameter int TIMEOUT    = TIMEOUT_DFLT,
  parameter int GAP_CYCLES = GAP_CYCLES_DFLT
) (
  input  logic                     clk_ram_ctl,
  input  logic                     rst_n,
  ingress_fabric_arbiter_if.slave  bus
);

  localparam int  IDX_W    = $clog2(NUM_PORTS);
  localparam int  WD_W     = wdog_width(TIMEOUT);
  localparam bit  SKIP_GAP = (GAP_CYCLES == 0);

  arb_state_t           state;
  logic [IDX_W-1:0]     ptr;
  logic [WD_W-1:0]      wdog;
  logic [1:0]           gap_cnt;
  logic [NUM_PORTS-1:0] forward_en_q;
  logic [IDX_W-1:0]     grant_port_q;
  logic                 timeout_evt_q;
  logic [COUNT_W-1:0]   timeout_count_q;

  logic [NUM_PORTS-1:0] req;
  logic                 found;
  logic [IDX_W-1:0]     winner;
  logic                 frame_done;
  logic                 wd_expire;
  logic                 gap_done;
  logic                 arbitrate;

  assign req = bus.frame_ready & bus.port_link_up;

  rr_priority_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .found  (found),
    .winner (winner)
  );

  assign frame_done = ((state == WAIT) || (state == BURST)) && bus.frame_valid && bus.frame_last;
  assign wd_expire  = (state == WAIT) && !bus.frame_valid && (wdog == WD_W'(TIMEOUT - 1));
  assign gap_done   = (state == GAP) && (gap_cnt == 2'(GAP_CYCLES - 1));

  // Arbitration happens in IDLE and on the edge that ends the turnaround;
  // with no turnaround the edge that ends a grant re-arbitrates at once,
  // giving back-to-back grants.
  assign arbitrate = (state == IDLE) || gap_done ||
                     (SKIP_GAP && (frame_done || wd_expire));

  always_ff @(posedge clk_ram_ctl or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      ptr             <= '0;
      wdog            <= '0;
      gap_cnt         <= '0;
      forward_en_q    <= '0;
      grant_port_q    <= '0;
      timeout_evt_q   <= 1'b0;
      timeout_count_q <= '0;
    end else begin
      timeout_evt_q <= wd_expire;
      if (wd_expire && (timeout_count_q != '1)) begin
        timeout_count_q <= timeout_count_q + 16'd1;
      end

      if (arbitrate) begin
        gap_cnt <= '0;
        if (found) begin
          forward_en_q <= NUM_PORTS'(1) << winner;
          grant_port_q <= winner;
          ptr          <= (winner == IDX_W'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
          wdog         <= '0;
          state        <= WAIT;
        end else begin
          forward_en_q <= '0;
          state        <= IDLE;
        end
      end else begin
        case (state)
          WAIT: begin
            if (frame_done || wd_expire) begin
              forward_en_q <= '0;
              gap_cnt      <= '0;
              state        <= GAP;
            end else if (bus.frame_valid) begin
              state <= BURST;
            end else begin
              wdog <= wdog + 1'b1;
            end
          end
          // Link loss mid-frame is deliberately ignored: the buffer still
          // flushes the tail, so only frame_last ends the grant.
          BURST: begin
            if (frame_done) begin
              forward_en_q <= '0;
              gap_cnt      <= '0;
              state        <= GAP;
            end
          end
          GAP: begin
            gap_cnt <= gap_cnt + 1'b1;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.forward_en    = forward_en_q;
  assign bus.grant_port    = grant_port_q;
  assign bus.timeout_evt   = timeout_evt_q;
  assign bus.timeout_count = timeout_count_q;

endmodule

// File: tb/tb_ingress_fabric_arbiter.sv
// tb/tb_ingress_fabric_arbiter.sv - bench for ingress_fabric_arbiter (gap 1 and gap 0 instances)

module tb_ingress_fabric_arbiter;

  localparam int NP      = 15;
  localparam int TIMEOUT = 64;

  typedef struct {
    int cur;       // granted port, -1 when no grant
    int last_gp;   // last granted index (grant_port value)
    bit beat;      // a beat has been seen for the current grant
    int waited;    // beatless cycles since the grant
    int gap_left;  // turnaround edges still to go
    int ptr;
    int cnt;
    bit evt;
  } mdl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NP-1:0] fr_drv = '0;
  logic [NP-1:0] lu_drv = '0;
  logic fv_drv = 1'b0;
  logic fl_drv = 1'b0;

  int errors = 0;
  int checks = 0;
  mdl_t m1, m0;

  always #5 clk = ~clk;

  ingress_fabric_arbiter_if #(.NUM_PORTS(NP)) if1 ();
  ingress_fabric_arbiter_if #(.NUM_PORTS(NP)) if0 ();

  assign if1.port_link_up = lu_drv;
  assign if1.frame_ready  = fr_drv;
  assign if1.frame_valid  = fv_drv;
  assign if1.frame_last   = fl_drv;
  assign if0.port_link_up = lu_drv;
  assign if0.frame_ready  = fr_drv;
  assign if0.frame_valid  = fv_drv;
  assign if0.frame_last   = fl_drv;

  ingress_fabric_arbiter #(.NUM_PORTS(NP), .TIMEOUT(TIMEOUT), .GAP_CYCLES(1)) dut1 (
    .clk_ram_ctl (clk),
    .rst_n       (rst_n),
    .bus         (if1)
  );

  ingress_fabric_arbiter #(.NUM_PORTS(NP), .TIMEOUT(TIMEOUT), .GAP_CYCLES(0)) dut0 (
    .clk_ram_ctl (clk),
    .rst_n       (rst_n),
    .bus         (if0)
  );

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.cur = -1; m.last_gp = 0; m.beat = 0; m.waited = 0;
    m.gap_left = 0; m.ptr = 0; m.cnt = 0; m.evt = 0;
    return m;
  endfunction

  // One clock edge of the scheduler rules, in terms of "who holds the bus".
  function automatic mdl_t model_step(input mdl_t m, input logic [NP-1:0] fr,
                                      input logic [NP-1:0] lu, input logic fv,
                                      input logic fl, input int gap);
    mdl_t n;
    bit release_now, arb, got;
    n = m;
    n.evt = 0;
    release_now = 0;
    arb = 0;
    if (m.cur >= 0) begin
      if (fv && fl) release_now = 1;
      else if (fv) n.beat = 1;
      else if (!m.beat) begin
        if (m.waited == TIMEOUT - 1) begin
          release_now = 1;
          n.evt = 1;
          if (n.cnt < 65535) n.cnt = n.cnt + 1;
        end else begin
          n.waited = m.waited + 1;
        end
      end
    end else if (m.gap_left > 0) begin
      if (m.gap_left == 1) arb = 1;
      else n.gap_left = m.gap_left - 1;
    end else begin
      arb = 1;
    end
    if (release_now) begin
      n.cur = -1;
      n.gap_left = gap;
      if (gap == 0) arb = 1;
    end
    if (arb) begin
      n.gap_left = 0;
      got = 0;
      for (int k = 0; k < NP; k++) begin
        int p;
        p = (m.ptr + k) % NP;
        if (!got && fr[p] && lu[p]) begin
          got = 1;
          n.cur = p; n.last_gp = p; n.ptr = (p + 1) % NP;
          n.beat = 0; n.waited = 0;
        end
      end
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input string tag, input mdl_t m, input logic [NP-1:0] fe,
                           input logic [3:0] gp, input logic evt, input logic [15:0] cnt);
    logic [NP-1:0] efe;
    efe = (m.cur >= 0) ? (NP'(1) << m.cur) : '0;
    check({tag, "_forward_en"}, 32'(fe), 32'(efe));
    check({tag, "_grant_port"}, 32'(gp), 32'(m.last_gp));
    check({tag, "_timeout_evt"}, 32'(evt), 32'(m.evt));
    check({tag, "_timeout_count"}, 32'(cnt), 32'(m.cnt));
  endtask

  // Called just after a falling edge; inputs are sampled on the next rising edge.
  task automatic step(input logic [NP-1:0] fr, input logic [NP-1:0] lu,
                      input logic fv, input logic fl);
    fr_drv = fr; lu_drv = lu; fv_drv = fv; fl_drv = fl;
    m1 = model_step(m1, fr, lu, fv, fl, 1);
    m0 = model_step(m0, fr, lu, fv, fl, 0);
    @(negedge clk);
    cmp_model("g1", m1, if1.forward_en, if1.grant_port, if1.timeout_evt, if1.timeout_count);
    cmp_model("g0", m0, if0.forward_en, if0.grant_port, if0.timeout_evt, if0.timeout_count);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("async_clear_fe_g1", 32'(if1.forward_en), 32'h0);
    check("async_clear_fe_g0", 32'(if0.forward_en), 32'h0);
    m1 = mdl_reset();
    m0 = mdl_reset();
    @(negedge clk);
    check("rst_fe", 32'(if1.forward_en), 32'h0);
    check("rst_gp", 32'(if1.grant_port), 32'h0);
    check("rst_evt", 32'(if1.timeout_evt), 32'h0);
    check("rst_cnt", 32'(if1.timeout_count), 32'h0);
    check("rst_cnt_g0", 32'(if0.timeout_count), 32'h0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int order [6];
    logic [NP-1:0] fr, lu;
    bit silent;
    order = '{0, 4, 14, 0, 4, 14};
    m1 = mdl_reset();
    m0 = mdl_reset();

    @(negedge clk);
    do_reset();

    // Single requester on port 3, 4-beat frame, regrant after one gap cycle.
    step(15'h0008, 15'h7FFF, 1'b0, 1'b0);
    check("s1_grant_fe", 32'(if1.forward_en), 32'h0008);
    check("s1_grant_gp", 32'(if1.grant_port), 32'd3);
    for (int b = 0; b < 3; b++) step(15'h0008, 15'h7FFF, 1'b1, 1'b0);
    check("s1_held_fe", 32'(if1.forward_en), 32'h0008);
    step(15'h0008, 15'h7FFF, 1'b1, 1'b1);
    check("s1_drop_fe", 32'(if1.forward_en), 32'h0);
    check("s1_g0_backtoback", 32'(if0.forward_en), 32'h0008);
    step(15'h0008, 15'h7FFF, 1'b0, 1'b0);
    check("s1_regrant_fe", 32'(if1.forward_en), 32'h0008);

    // Fairness across ports 0, 4, 14 with 2-beat frames.
    do_reset();
    step(15'h4011, 15'h7FFF, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      check("s2_order", 32'(if1.grant_port), 32'(order[k]));
      step(15'h4011, 15'h7FFF, 1'b1, 1'b0);
      step(15'h4011, 15'h7FFF, 1'b1, 1'b1);
      step(15'h4011, 15'h7FFF, 1'b0, 1'b0);
    end

    // Link masking, and link drop in BURST holds the grant.
    do_reset();
    step(15'h7FFF, 15'h0010, 1'b0, 1'b0);
    check("s3_grant4", 32'(if1.forward_en), 32'h0010);
    step(15'h7FFF, 15'h0010, 1'b1, 1'b0);
    step(15'h7FFF, 15'h0000, 1'b0, 1'b0);
    check("s3_held_linkdown", 32'(if1.forward_en), 32'h0010);
    step(15'h7FFF, 15'h0000, 1'b1, 1'b1);
    check("s3_release", 32'(if1.forward_en), 32'h0);
    for (int k = 0; k < 3; k++) step(15'h7FFF, 15'h0000, 1'b0, 1'b0);
    check("s3_no_more", 32'(if1.forward_en), 32'h0);

    // Watchdog on port 7; next grant goes to 8.
    do_reset();
    step(15'h0180, 15'h7FFF, 1'b0, 1'b0);
    check("s4_grant7", 32'(if1.forward_en), 32'h0080);
    for (int k = 0; k < 63; k++) step(15'h0180, 15'h7FFF, 1'b0, 1'b0);
    check("s4_still64", 32'(if1.forward_en), 32'h0080);
    check("s4_no_evt_yet", 32'(if1.timeout_evt), 32'h0);
    step(15'h0180, 15'h7FFF, 1'b0, 1'b0);
    check("s4_abort_fe", 32'(if1.forward_en), 32'h0);
    check("s4_evt", 32'(if1.timeout_evt), 32'h1);
    check("s4_count", 32'(if1.timeout_count), 32'h1);
    step(15'h0180, 15'h7FFF, 1'b0, 1'b0);
    check("s4_evt_once", 32'(if1.timeout_evt), 32'h0);
    check("s4_next_gp", 32'(if1.grant_port), 32'd8);

    // Single-beat frames with no turnaround.
    do_reset();
    step(15'h0222, 15'h7FFF, 1'b0, 1'b0);
    check("s5_g0_p1", 32'(if0.forward_en), 32'h0002);
    step(15'h0222, 15'h7FFF, 1'b1, 1'b1);
    check("s5_g0_p5", 32'(if0.forward_en), 32'h0020);
    step(15'h0222, 15'h7FFF, 1'b1, 1'b1);
    check("s5_g0_p9", 32'(if0.forward_en), 32'h0200);
    step(15'h0222, 15'h7FFF, 1'b1, 1'b1);
    check("s5_g0_wrap_p1", 32'(if0.forward_en), 32'h0002);

    // Async reset mid-BURST on port 9, then pointer restarts at 0.
    do_reset();
    step(15'h0200, 15'h7FFF, 1'b0, 1'b0);
    step(15'h0200, 15'h7FFF, 1'b1, 1'b0);
    check("s6_burst9", 32'(if1.forward_en), 32'h0200);
    do_reset();
    step(15'h0404, 15'h7FFF, 1'b0, 1'b0);
    check("s6_first2", 32'(if1.grant_port), 32'd2);

    // Randomized traffic against the model.
    do_reset();
    fr = NP'($urandom);
    lu = '1;
    silent = 0;
    for (int c = 0; c < 3000; c++) begin
      logic fv, fl;
      if ($urandom_range(0, 7) == 0) fr = NP'($urandom);
      if ($urandom_range(0, 15) == 0) lu = ~NP'($urandom & $urandom & $urandom);
      if (m1.cur >= 0 && !silent) begin
        fv = ($urandom_range(0, 1) == 1);
        fl = fv && ($urandom_range(0, 2) == 0);
      end else if (m1.cur < 0) begin
        fv = ($urandom_range(0, 15) == 0);
        fl = ($urandom_range(0, 1) == 1);
      end else begin
        fv = 1'b0;
        fl = 1'b0;
      end
      step(fr, lu, fv, fl);
      if (m1.cur >= 0 && m1.waited == 0 && !m1.beat) silent = ($urandom_range(0, 7) == 0);
      if (m1.cur < 0) silent = 0;
      if (c % 900 == 899) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
